// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the pingpong_hold stage.
// Optional hold checking is enabled with PINGPONG_HOLD_CHECK_EN.
package pingpong_pkg;

    typedef enum logic {
        BANK_G = 1'b0,
        BANK_S = 1'b1
    } bank_t;

    // HOLD=0 still needs a legal 1-bit counter vector.
    function automatic int unsigned hold_w(input int unsigned hold);
        return (hold == 0) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/pingpong_hold_bank.sv
// One held data bank with an optional minimum-hold down-counter.
// The counter exists only when PINGPONG_HOLD_CHECK_EN is defined.
module hold_bank
    import pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (cap_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

`ifdef PINGPONG_HOLD_CHECK_EN
    localparam int unsigned    CW      = hold_w(HOLD);
    localparam logic [CW-1:0]  HOLD_LD = CW'(HOLD);

    logic [CW-1:0] cnt_q, cnt_d;

    // Captures are only issued to a free bank, so the load never races a count.
    always_comb begin
        cnt_d = cnt_q;
        if (cap_i) begin
            cnt_d = HOLD_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
`else
    logic unused_hold;
    assign unused_hold = (HOLD != 0);
    assign busy_o      = 1'b0;
`endif

endmodule

// File: rtl/pingpong_hold.sv
// Alternating two-bank capture stage producing go_G/go_S pulses for the merge.
// Define PINGPONG_HOLD_CHECK_EN to reject captures into a bank still in its hold window.
module pingpong_hold
    import pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             go_G,
    output logic             go_S,
    output logic             err
);

    bank_t sel_q, sel_d;
    logic  go_G_q, go_G_d;
    logic  go_S_q, go_S_d;
    logic  busy0, busy1;
    logic  target_busy;
    logic  accept;
    logic  cap0, cap1;

    // Busy is constant 0 without the checker, so accept collapses to go.
    assign target_busy = (sel_q == BANK_G) ? busy0 : busy1;
    assign accept      = go & ~target_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= BANK_G;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (accept) begin
            sel_d = (sel_q == BANK_G) ? BANK_S : BANK_G;
        end
    end

    always_comb begin
        cap0   = accept && (sel_q == BANK_G);
        cap1   = accept && (sel_q == BANK_S);
        go_G_d = cap0;
        go_S_d = cap1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            go_G_q <= 1'b0;
            go_S_q <= 1'b0;
        end else begin
            go_G_q <= go_G_d;
            go_S_q <= go_S_d;
        end
    end

    assign go_G = go_G_q;
    assign go_S = go_S_q;

    hold_bank #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) u_bank0 (
        .clk    (clk),
        .reset  (reset),
        .cap_i  (cap0),
        .data_i (in),
        .data_o (out0),
        .busy_o (busy0)
    );

    hold_bank #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) u_bank1 (
        .clk    (clk),
        .reset  (reset),
        .cap_i  (cap1),
        .data_i (in),
        .data_o (out1),
        .busy_o (busy1)
    );

`ifdef PINGPONG_HOLD_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (go & target_busy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_hold.sv
// Scoreboard bench for pingpong_hold: three instances (HOLD=2, 1, 4), WIDTH=8.
module tb_pingpong_hold;

`ifdef PINGPONG_HOLD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int         due;
        bit         bank;
        logic [7:0] data;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] go_v;
    logic [7:0] in_v [3];
    logic [7:0] o0   [3];
    logic [7:0] o1   [3];
    logic [2:0] gG, gS, er;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pingpong_hold #(.WIDTH(8), .HOLD(2)) u_h2 (
        .clk(clk), .reset(rst), .go(go_v[0]), .in(in_v[0]),
        .out0(o0[0]), .out1(o1[0]), .go_G(gG[0]), .go_S(gS[0]), .err(er[0])
    );

    pingpong_hold #(.WIDTH(8), .HOLD(1)) u_h1 (
        .clk(clk), .reset(rst), .go(go_v[1]), .in(in_v[1]),
        .out0(o0[1]), .out1(o1[1]), .go_G(gG[1]), .go_S(gS[1]), .err(er[1])
    );

    pingpong_hold #(.WIDTH(8), .HOLD(4)) u_h4 (
        .clk(clk), .reset(rst), .go(go_v[2]), .in(in_v[2]),
        .out0(o0[2]), .out1(o1[2]), .go_G(gG[2]), .go_S(gS[2]), .err(er[2])
    );

    task automatic test_reset();
        logic [7:0] x0, x1;
        bit         te;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                checks++;
                if ({gG[0], gS[0]} !== 2'b00) begin
                    failures++;
                    $display("FAIL reset_pulse cyc %0d: got G/S=%b%b want 00", n, gG[0], gS[0]);
                end
                checks++;
                if (o0[0] !== x0 || o1[0] !== x1) begin
                    failures++;
                    $display("FAIL reset_out cyc %0d: got %h/%h want %h/%h", n, o0[0], o1[0], x0, x1);
                end
                checks++;
                if (er[0] !== te) begin
                    failures++;
                    $display("FAIL reset_err cyc %0d: got %b want %b", n, er[0], te);
                end
            end
            rst     = (n < 2);
            go_v[0] = 1'b0;
            in_v[0] = 8'hFF;
            if (rst) begin x0 = '0; x1 = '0; te = 1'b0; end
        end
    endtask

    task automatic test_single();
        sb_t        q[$];
        sb_t        e;
        logic [7:0] x0, x1;
        bit         ts, te, pg, ps;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                pg = 1'b0; ps = 1'b0;
                if (q.size() != 0 && q[0].due == n) begin
                    e = q.pop_front();
                    if (e.bank) begin ps = 1'b1; x1 = e.data; end
                    else        begin pg = 1'b1; x0 = e.data; end
                end
                checks++;
                if ({gG[0], gS[0]} !== {pg, ps}) begin
                    failures++;
                    $display("FAIL single_pulse cyc %0d: got G/S=%b%b want %b%b", n, gG[0], gS[0], pg, ps);
                end
                checks++;
                if (o0[0] !== x0 || o1[0] !== x1) begin
                    failures++;
                    $display("FAIL single_out cyc %0d: got %h/%h want %h/%h", n, o0[0], o1[0], x0, x1);
                end
            end
            rst     = (n < 2);
            go_v[0] = (n == 3);
            in_v[0] = 8'hA5;
            if (rst) begin x0 = '0; x1 = '0; ts = 1'b0; te = 1'b0; q.delete(); end
            else if (go_v[0]) begin q.push_back('{n + 1, ts, in_v[0]}); ts = !ts; end
        end
        go_v[0] = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL single_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_alternation();
        sb_t        q[$];
        sb_t        e;
        logic [7:0] x0, x1;
        bit         ts, te, pg, ps;
        for (int n = 0; n < 13; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                pg = 1'b0; ps = 1'b0;
                if (q.size() != 0 && q[0].due == n) begin
                    e = q.pop_front();
                    if (e.bank) begin ps = 1'b1; x1 = e.data; end
                    else        begin pg = 1'b1; x0 = e.data; end
                end
                checks++;
                if ({gG[0], gS[0]} !== {pg, ps}) begin
                    failures++;
                    $display("FAIL alt_pulse cyc %0d: got G/S=%b%b want %b%b", n, gG[0], gS[0], pg, ps);
                end
                checks++;
                if (o0[0] !== x0 || o1[0] !== x1) begin
                    failures++;
                    $display("FAIL alt_out cyc %0d: got %h/%h want %h/%h", n, o0[0], o1[0], x0, x1);
                end
                checks++;
                if (er[0] !== te) begin
                    failures++;
                    $display("FAIL alt_err cyc %0d: got %b want %b", n, er[0], te);
                end
            end
            rst     = (n < 2);
            go_v[0] = (n == 3) || (n == 6) || (n == 9);
            in_v[0] = (n == 3) ? 8'h11 : (n == 6) ? 8'h22 : (n == 9) ? 8'h33 : 8'hEE;
            if (rst) begin x0 = '0; x1 = '0; ts = 1'b0; te = 1'b0; q.delete(); end
            else if (go_v[0]) begin q.push_back('{n + 1, ts, in_v[0]}); ts = !ts; end
        end
        go_v[0] = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL alt_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        sb_t        q[$];
        sb_t        e;
        logic [7:0] x0, x1;
        bit         ts, te, pg, ps;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                pg = 1'b0; ps = 1'b0;
                if (q.size() != 0 && q[0].due == n) begin
                    e = q.pop_front();
                    if (e.bank) begin ps = 1'b1; x1 = e.data; end
                    else        begin pg = 1'b1; x0 = e.data; end
                end
                checks++;
                if ({gG[1], gS[1]} !== {pg, ps}) begin
                    failures++;
                    $display("FAIL b2b_pulse cyc %0d: got G/S=%b%b want %b%b", n, gG[1], gS[1], pg, ps);
                end
                checks++;
                if (o0[1] !== x0 || o1[1] !== x1) begin
                    failures++;
                    $display("FAIL b2b_out cyc %0d: got %h/%h want %h/%h", n, o0[1], o1[1], x0, x1);
                end
                checks++;
                if (er[1] !== te) begin
                    failures++;
                    $display("FAIL b2b_err cyc %0d: got %b want %b", n, er[1], te);
                end
            end
            rst     = (n < 2);
            go_v[1] = (n >= 3) && (n <= 6);
            in_v[1] = 8'(n - 2);
            if (rst) begin x0 = '0; x1 = '0; ts = 1'b0; te = 1'b0; q.delete(); end
            else if (go_v[1]) begin q.push_back('{n + 1, ts, in_v[1]}); ts = !ts; end
        end
        go_v[1] = 1'b0;
        checks++;
        if (o0[1] !== 8'd3 || o1[1] !== 8'd4) begin
            failures++;
            $display("FAIL b2b_final: got %h/%h want 03/04", o0[1], o1[1]);
        end
    endtask

    task automatic test_hold_violation();
        sb_t        q[$];
        sb_t        e;
        logic [7:0] x0, x1;
        bit         ts, te, pg, ps, acc;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                pg = 1'b0; ps = 1'b0;
                if (q.size() != 0 && q[0].due == n) begin
                    e = q.pop_front();
                    if (e.bank) begin ps = 1'b1; x1 = e.data; end
                    else        begin pg = 1'b1; x0 = e.data; end
                end
                checks++;
                if ({gG[2], gS[2]} !== {pg, ps}) begin
                    failures++;
                    $display("FAIL hold_pulse cyc %0d: got G/S=%b%b want %b%b", n, gG[2], gS[2], pg, ps);
                end
                checks++;
                if (o0[2] !== x0 || o1[2] !== x1) begin
                    failures++;
                    $display("FAIL hold_out cyc %0d: got %h/%h want %h/%h", n, o0[2], o1[2], x0, x1);
                end
                checks++;
                if (er[2] !== te) begin
                    failures++;
                    $display("FAIL hold_err cyc %0d: got %b want %b", n, er[2], te);
                end
            end
            rst     = (n < 2);
            go_v[2] = (n >= 3) && (n <= 5);
            in_v[2] = 8'(n + 4);
            // Third go re-targets bank 0 one cycle into its 4-cycle hold.
            acc     = !(CHK && n == 5);
            if (rst) begin x0 = '0; x1 = '0; ts = 1'b0; te = 1'b0; q.delete(); end
            else if (go_v[2]) begin
                if (acc) begin q.push_back('{n + 1, ts, in_v[2]}); ts = !ts; end
                else te = 1'b1;
            end
        end
        go_v[2] = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL hold_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        sb_t        q[$];
        sb_t        e;
        logic [7:0] x0, x1;
        bit         ts, te, pg, ps;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                pg = 1'b0; ps = 1'b0;
                if (q.size() != 0 && q[0].due == n) begin
                    e = q.pop_front();
                    if (e.bank) begin ps = 1'b1; x1 = e.data; end
                    else        begin pg = 1'b1; x0 = e.data; end
                end
                checks++;
                if ({gG[0], gS[0]} !== {pg, ps}) begin
                    failures++;
                    $display("FAIL rmid_pulse cyc %0d: got G/S=%b%b want %b%b", n, gG[0], gS[0], pg, ps);
                end
                checks++;
                if (o0[0] !== x0 || o1[0] !== x1) begin
                    failures++;
                    $display("FAIL rmid_out cyc %0d: got %h/%h want %h/%h", n, o0[0], o1[0], x0, x1);
                end
                checks++;
                if (er[0] !== te) begin
                    failures++;
                    $display("FAIL rmid_err cyc %0d: got %b want %b", n, er[0], te);
                end
            end
            rst     = (n < 2) || (n == 6);
            go_v[0] = (n == 3) || (n == 4) || (n == 6) || (n == 8);
            in_v[0] = (n == 3) ? 8'h11 : (n == 4) ? 8'h22 : (n == 6) ? 8'h55 : 8'h66;
            if (rst) begin x0 = '0; x1 = '0; ts = 1'b0; te = 1'b0; q.delete(); end
            else if (go_v[0]) begin q.push_back('{n + 1, ts, in_v[0]}); ts = !ts; end
        end
        go_v[0] = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rmid_drain: got %0d pending want 0", q.size());
        end
    endtask

    initial begin
        rst  = 1'b1;
        go_v = '0;
        for (int i = 0; i < 3; i++) in_v[i] = '0;
        test_reset();
        test_single();
        test_alternation();
        test_back_to_back();
        test_hold_violation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pingpong_hold.md
Name: pingpong_hold

Overview:
- Upstream companion stage for the two-input event-selected merge primitive.
- Accepts a single data stream qualified by a one-cycle `go` event.
- Alternately captures each value into one of two banks and holds it stable until that bank is next written.
- Emits the `go_G` / `go_S` event pulses that drive the merge, so the merge's held-input requirement is met by construction.

Parameters:
- WIDTH, 32, data width of `in`, `out0` and `out1`.
- HOLD, 2, minimum cycles a bank must stay stable after capture before it may be overwritten; 0 disables the constraint.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; one clock domain.
- go  input  1  one-cycle event: capture `in` this cycle.
- in  input  WIDTH  data, sampled only when `go`=1.
- out0  output  WIDTH  bank 0 held value; feeds merge `in0`.
- out1  output  WIDTH  bank 1 held value; feeds merge `in1`.
- go_G  output  1  one-cycle pulse: bank 0 updated; feeds merge `go_G`.
- go_S  output  1  one-cycle pulse: bank 1 updated; feeds merge `go_S`.
- err  output  1  sticky hold-violation flag; present only when the optional feature is compiled in, tied 0 otherwise.

Behaviour:
- Reset values:
  - `sel` (next bank to write) = 0.
  - `out0` = `out1` = 0.
  - `go_G` = `go_S` = 0.
  - Hold counters = 0.
  - `err` = 0.
- Reset has priority over `go`; a `go` in a reset cycle is ignored.
- Accepted `go` in cycle N:
  - Edge N: `bank[sel]` <= `in`, and `sel` toggles.
  - Cycle N+1: exactly one of `go_G` (`sel` was 0) or `go_S` (`sel` was 1) is high for one cycle.
  - The matching `out*` shows the new value from N+1 onward.
  - Latency `go` -> pulse = 1 cycle.
  - Data is valid in the same cycle as its pulse, as the merge requires.
- Held bank: unchanged until its next accepted capture. The other bank is never disturbed.
- Back-to-back `go` every cycle with HOLD ≤ 1 is legal:
  - Pulses alternate G, S, G, S…
  - Both banks keep their values.
- Pulse signals are mutually exclusive and never high for two consecutive cycles on the same signal, unless two accepted captures target the same bank. That is impossible by the toggle rule.
- No `go`: all state holds, pulses low.

Optional Feature:
- Macro: PINGPONG_HOLD_CHECK_EN.
- Defined:
  - Per-bank down-counter of width $clog2(HOLD+1).
  - Counter loads HOLD on capture and decrements to 0, saturating at 0.
  - A bank is busy while its counter is nonzero.
  - A `go` that targets a busy bank is rejected:
    - No capture.
    - `sel` is unchanged.
    - No pulse.
    - `err` goes high on the next edge and stays high until reset.
  - A capture and a counter reaching 0 in the same cycle: the bank is free, and the capture is accepted.
- Undefined: no counters, every `go` is accepted, `err` tied 0.
- HOLD=0 behaves identically in both builds, apart from `err` staying 0.

Decomposition:
- Shared package `pingpong_pkg`:
  - `bank_t` enum: BANK_G=0, BANK_S=1.
  - Function `hold_w(HOLD)` returning the counter width.
- Natural sub-module `hold_bank`, instantiated twice:
  - Contents: WIDTH data register, capture enable, optional hold counter, busy output.
- The top level owns `sel`, the pulse registers and `err`.

Test Plan:
- Reset then idle (WIDTH=8, HOLD=2): `reset`=1 for 2 cycles, then 5 idle cycles -> `out0`=`out1`=0, `go_G`=`go_S`=0, `err`=0 throughout.
- Single capture: `go`=1 with `in`=8'hA5 at cycle 3 -> `go_G`=1 at cycle 4 only, `out0`=A5 from cycle 4, `out1`=0.
- Alternation: `go` at cycles 3, 6, 9 with 11, 22, 33 -> pulses:
  - `go_G`@4 with `out0`=11.
  - `go_S`@7 with `out1`=22.
  - `go_G`@10 with `out0`=33.
  - `out1` stays 22 after cycle 7.
- Back-to-back (HOLD=1): `go` at cycles 3..6 with 1, 2, 3, 4 -> pulses G@4, S@5, G@6, S@7, then final `out0`=3, `out1`=4.
- Hold violation (HOLD=4, PINGPONG_HOLD_CHECK_EN defined): `go` at cycles 3, 4, 5 with 7, 8, 9 -> cycle-5 capture (bank 0 busy) rejected; `out0` stays 7, no pulse at 6, `err`=1 from 6. Same stimulus without the macro -> `out0`=9 from 6, `err`=0.
- Reset mid-operation: `go`=1 with 8'h55 in the same cycle as `reset`=1, after prior captures -> next cycle everything is 0, no pulse; the next `go` writes bank 0 and pulses `go_G`.
